gigatron_video: RTL and testbench

GIGATRON_VIDEO -- requirements
Module: gigatron_video

---
 rtl/gigatron_video_pkg.sv | 15 +
 rtl/gigatron_video_fifo.sv | 52 +++++
 rtl/gigatron_video.sv | 114 +++++++++++
 tb/tb_gigatron_video.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gigatron_video_pkg.sv
// Shared constants and FIFO entry layout for the Gigatron OUT-register video capture.
package gigatron_video_pkg;

    localparam int H_ACTIVE  = 160;
    localparam int V_ACTIVE  = 480;
    localparam int HSYNC_BIT = 6;
    localparam int VSYNC_BIT = 7;

    typedef struct packed {
        logic [5:0] pixel;
        logic [7:0] x;
        logic [8:0] y;
    } pixel_entry_t;

endpackage

// File: rtl/gigatron_video_fifo.sv
// Small synchronous FIFO for captured pixels; a push that finds no room is dropped and flagged.
module gigatron_video_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_drop
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign full    = (count == FULL_COUNT);
    assign o_valid = (count != '0);
    assign do_pop  = o_valid && i_pop;
    assign do_push = i_push && (!full || do_pop);
    assign o_drop  = i_push && !do_push;
    assign o_data  = o_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (do_push) mem[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/gigatron_video.sv
// Turns the Gigatron OUT register stream into (x, y, colour) pixels behind a valid/ready FIFO.
module gigatron_video
    import gigatron_video_pkg::*;
#(
    parameter int H_START    = 48,
    parameter int V_START    = 35,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_ce,
    input  logic [7:0] i_out,
    input  logic       i_clear,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [5:0] o_pixel,
    output logic [7:0] o_x,
    output logic [8:0] o_y,
    output logic       o_sof,
    output logic       o_overflow,
    output logic [9:0] o_lines
);

    localparam logic [9:0] CNT_MAX = 10'd1023;
    localparam logic [9:0] H_LO    = 10'(H_START);
    localparam logic [9:0] H_HI    = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] V_LO    = 10'(V_START);
    localparam logic [9:0] V_HI    = 10'(V_START + V_ACTIVE);

    logic         hsync_q;
    logic         vsync_q;
    logic [9:0]   col_q;
    logic [9:0]   row_q;
    logic [9:0]   lines_q;
    logic         locked_q;
    logic         stage_ce_q;
    logic [5:0]   stage_pix_q;
    logic         overflow_q;
    logic         h_fall;
    logic         v_fall;
    logic         push;
    logic         fifo_drop;
    pixel_entry_t push_entry;
    pixel_entry_t head;

    assign h_fall = !i_out[HSYNC_BIT] && hsync_q;
    assign v_fall = !i_out[VSYNC_BIT] && vsync_q;

    // col_q/row_q hold the position of the latest sample; the push is evaluated one cycle later.
    // Nothing is pushed until a vsync fall has been seen, so rows are frame-relative.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            col_q       <= '0;
            row_q       <= '0;
            lines_q     <= '0;
            locked_q    <= 1'b0;
            stage_ce_q  <= 1'b0;
            stage_pix_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            stage_ce_q <= i_ce;
            if (i_ce) begin
                hsync_q     <= i_out[HSYNC_BIT];
                vsync_q     <= i_out[VSYNC_BIT];
                stage_pix_q <= i_out[5:0];
                if (h_fall)               col_q <= '0;
                else if (col_q != CNT_MAX) col_q <= col_q + 1'b1;
                if (v_fall) begin
                    lines_q  <= row_q;
                    row_q    <= '0;
                    locked_q <= 1'b1;
                end else if (h_fall && row_q != CNT_MAX) begin
                    row_q <= row_q + 1'b1;
                end
            end
            if (fifo_drop)    overflow_q <= 1'b1;
            else if (i_clear) overflow_q <= 1'b0;
        end
    end

    assign push = stage_ce_q && locked_q
               && (col_q >= H_LO) && (col_q < H_HI)
               && (row_q >= V_LO) && (row_q < V_HI);

    assign push_entry = '{pixel: stage_pix_q,
                          x:     8'(col_q - H_LO),
                          y:     9'(row_q - V_LO)};

    // Handshake: o_valid means a head pixel is presented; it is consumed on any rising
    // edge where o_valid && i_ready, and the head stays unchanged while i_ready is low.
    gigatron_video_fifo #(
        .WIDTH ($bits(pixel_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (push),
        .i_data  (push_entry),
        .i_pop   (i_ready),
        .o_valid (o_valid),
        .o_data  (head),
        .o_drop  (fifo_drop)
    );

    assign o_pixel    = head.pixel;
    assign o_x        = head.x;
    assign o_y        = head.y;
    assign o_sof      = o_valid && (head.x == '0) && (head.y == '0);
    assign o_overflow = overflow_q;
    assign o_lines    = lines_q;

endmodule

// File: tb/tb_gigatron_video.sv
// Directed bench for gigatron_video: compressed frames, backpressure/overflow, reset and saturation.
module tb_gigatron_video;

    localparam int H_START = 48;
    localparam int V_START = 35;
    localparam int DEPTH   = 8;
    localparam int LONG    = 212;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_ce;
    logic [7:0] i_out;
    logic       i_clear;
    logic       i_ready;
    logic       o_valid;
    logic [5:0] o_pixel;
    logic [7:0] o_x;
    logic [8:0] o_y;
    logic       o_sof;
    logic       o_overflow;
    logic [9:0] o_lines;

    logic [22:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rx    = 0;
    logic        vs_level = 1'b1;

    gigatron_video #(
        .H_START    (H_START),
        .V_START    (V_START),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_ce       (i_ce),
        .i_out      (i_out),
        .i_clear    (i_clear),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_pixel    (o_pixel),
        .o_x        (o_x),
        .o_y        (o_y),
        .o_sof      (o_sof),
        .o_overflow (o_overflow),
        .o_lines    (o_lines)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=bench completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every accepted head pixel is compared with the front of the expected queue.
    task automatic pop_check();
        logic [22:0] e;
        n_cmp++;
        assert (exp_q.size() > 0) else begin
            n_bad++;
            $error("FAIL unexpected_pop observed x=%0d y=%0d expected=no pixel", o_x, o_y);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pixel", 32'({o_pixel, o_x, o_y}), 32'(e));
            check("sof", 32'(o_sof), 32'(e[16:0] == 17'd0));
            rx++;
        end
    endtask

    // Called at a falling edge: apply inputs, account for the handshake at the next rising edge.
    task automatic cyc(input logic ce, input logic [7:0] out);
        i_ce  = ce;
        i_out = out;
        if (o_valid && i_ready) pop_check();
        @(negedge i_clock);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, i_out);
    endtask

    task automatic sample(input logic hs, input logic vs, input logic [5:0] colour,
                          input int cp, input bit lat);
        cyc(1'b1, {vs, hs, colour});
        for (int k = 1; k < cp; k++) begin
            if (lat && k == 1) check("latency_n1", 32'(o_valid), 0);
            if (lat && k == 2) check("latency_n2", 32'(o_valid), 1);
            cyc(1'b0, {vs, hs, colour});
        end
    endtask

    // One line: hsync falls at sample 0, vsync (if it changes) moves at sample 1.
    task automatic line(input int n, input int y_exp, input logic vs, input int cp, input int ready_col);
        int         hlow;
        logic [5:0] colour;
        logic       vbit;
        hlow = (n >= 48) ? 24 : 1;
        for (int c = 0; c < n; c++) begin
            colour = 6'(c * 5 + y_exp * 3 + 1);
            vbit   = (c == 0) ? vs_level : vs;
            if (c == ready_col) i_ready = 1'b1;
            if (y_exp >= 0 && c >= H_START && c < H_START + 160)
                exp_q.push_back({colour, 8'(c - H_START), 9'(y_exp)});
            sample(c >= hlow, vbit, colour, cp, (cp > 2 && y_exp == 0 && c == H_START));
        end
        vs_level = vs;
    endtask

    // 521-row frame; only rows 35, 36, 514 (visible) and 515 (just past the window) are full width.
    task automatic frame(input int cp);
        line(2, -1, 1'b0, cp, -1);
        line(2, -1, 1'b0, cp, -1);
        for (int r = 2; r < V_START; r++) line(2, -1, 1'b1, cp, -1);
        line(LONG, 0, 1'b1, cp, -1);
        line(LONG, 1, 1'b1, cp, -1);
        for (int r = V_START + 2; r < V_START + 479; r++) line(2, -1, 1'b1, cp, -1);
        line(LONG, 479, 1'b1, cp, -1);
        line(LONG, -1, 1'b1, cp, -1);
        for (int r = V_START + 481; r < 521; r++) line(2, -1, 1'b1, cp, -1);
    endtask

    initial begin
        i_reset = 1'b0;
        i_ce    = 1'b0;
        i_out   = 8'hC0;
        i_clear = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(negedge i_clock);
        check("rst_valid",    32'(o_valid), 0);
        check("rst_sof",      32'(o_sof), 0);
        check("rst_pixel",    32'(o_pixel), 0);
        check("rst_x",        32'(o_x), 0);
        check("rst_y",        32'(o_y), 0);
        check("rst_overflow", 32'(o_overflow), 0);
        check("rst_lines",    32'(o_lines), 0);
        i_reset = 1'b1;
        @(negedge i_clock);

        // Full-rate frame
        frame(1);
        line(2, -1, 1'b0, 1, -1);
        check("lines_full_rate", 32'(o_lines), 521);
        drain(20);
        check("rx_full_rate", rx, 480);
        check("exp_empty_full_rate", exp_q.size(), 0);
        line(2, -1, 1'b1, 1, -1);

        // Same frame with i_ce one cycle in four
        rx = 0;
        frame(4);
        line(2, -1, 1'b0, 4, -1);
        check("lines_ce4", 32'(o_lines), 521);
        drain(20);
        check("rx_ce4", rx, 480);
        check("exp_empty_ce4", exp_q.size(), 0);
        line(2, -1, 1'b1, 1, -1);

        // Backpressure for a whole line: only the first DEPTH pixels are kept
        line(2, -1, 1'b0, 1, -1);
        line(2, -1, 1'b0, 1, -1);
        for (int r = 2; r < V_START; r++) line(2, -1, 1'b1, 1, -1);
        i_ready = 1'b0;
        line(LONG, 0, 1'b1, 1, -1);
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        check("ovf_set", 32'(o_overflow), 1);
        check("ovf_valid", 32'(o_valid), 1);
        check("head_hold_a", 32'({o_pixel, o_x, o_y}), 32'(exp_q[0]));
        drain(3);
        check("head_hold_b", 32'({o_pixel, o_x, o_y}), 32'(exp_q[0]));
        i_clear = 1'b1;
        for (int c = 0; c < LONG; c++) begin
            sample(c >= 24, 1'b1, 6'd0, 1, 1'b0);
            if (c == 100) check("ovf_beats_clear", 32'(o_overflow), 1);
        end
        check("ovf_cleared", 32'(o_overflow), 0);
        i_clear = 1'b0;
        line(LONG, 2, 1'b1, 1, 49);
        check("ovf_full_push_pop", 32'(o_overflow), 0);
        drain(20);
        check("exp_empty_ovf", exp_q.size(), 0);
        check("drained_valid", 32'(o_valid), 0);

        // Reset in the middle of row 200 with pixels still queued
        i_ready = 1'b0;
        line(LONG, 3, 1'b1, 1, -1);
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        for (int r = V_START + 4; r < 200; r++) line(2, -1, 1'b1, 1, -1);
        line(30, -1, 1'b1, 1, -1);
        check("pre_reset_valid", 32'(o_valid), 1);
        i_reset = 1'b0;
        #1;
        check("mid_rst_valid",    32'(o_valid), 0);
        check("mid_rst_sof",      32'(o_sof), 0);
        check("mid_rst_pixel",    32'(o_pixel), 0);
        check("mid_rst_x",        32'(o_x), 0);
        check("mid_rst_y",        32'(o_y), 0);
        check("mid_rst_overflow", 32'(o_overflow), 0);
        check("mid_rst_lines",    32'(o_lines), 0);
        exp_q.delete();
        rx      = 0;
        i_ready = 1'b1;
        repeat (2) @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);

        // No output before a vsync fall, even past V_START hsync falls
        for (int r = 0; r < 40; r++) line(2, -1, 1'b1, 1, -1);
        line(LONG, -1, 1'b1, 1, -1);
        drain(10);
        check("no_px_unlocked", rx, 0);
        check("unlocked_valid", 32'(o_valid), 0);

        // hsync and vsync fall on the same sample
        sample(1'b0, 1'b0, 6'd0, 1, 1'b0);
        check("coincident_row", 32'(dut.row_q), 0);
        check("coincident_col", 32'(dut.col_q), 0);
        check("coincident_lines", 32'(o_lines), 41);
        sample(1'b1, 1'b0, 6'd0, 1, 1'b0);
        sample(1'b0, 1'b0, 6'd0, 1, 1'b0);
        check("next_row", 32'(dut.row_q), 1);
        check("next_col", 32'(dut.col_q), 0);
        sample(1'b1, 1'b0, 6'd0, 1, 1'b0);
        vs_level = 1'b0;
        for (int r = 2; r < V_START; r++) line(2, -1, 1'b1, 1, -1);
        line(LONG, 0, 1'b1, 1, -1);

        // Long line: column saturates and never re-enters the visible window
        line(2001, 1, 1'b1, 1, -1);
        check("col_sat", 32'(dut.col_q), 1023);
        drain(20);
        check("rx_after_reset", rx, 320);
        check("exp_empty_end", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
